param_register_file: RTL
========================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter XLEN, default 64, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, >= 2; AW = clog2(NREGS).
REQ-003 Parameter NREAD, default 2, number of read ports, 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = no forwarding.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 read_reg  input  NREAD*AW  read addresses; port i in bits [i*AW +: AW].
REQ-008 read_data  output  NREAD*XLEN  read data; port i in bits [i*XLEN +: XLEN].
REQ-009 read_busy  output  NREAD  per read port: addressed register has a pending write.
REQ-010 reg_write  input  1  write enable.
REQ-011 write_reg  input  AW  write address.
REQ-012 write_data  input  XLEN  write data.
REQ-013 issue_valid  input  1  mark issue_reg as pending-write (scoreboard set).
REQ-014 issue_reg  input  AW  register to mark busy.
REQ-015 busy_count  output  AW+1  number of registers currently busy.

Function
REQ-016 Storage: NREGS x XLEN registers; register 0 reads as 0 at all times.
REQ-017 Write: on rising clk with reg_write=1 and write_reg!=0, register[write_reg] <= write_data; write_reg=0 is ignored.
REQ-018 Read: read_data port i is combinational from read_reg port i; all ports independent, any address, duplicates allowed.
REQ-019 BYPASS=1: if reg_write=1, write_reg!=0 and read_reg_i==write_reg, read_data_i = write_data in the same cycle.
REQ-020 BYPASS=0: read returns stored value; the new value is visible the cycle after the write edge.
REQ-021 Scoreboard: one busy bit per register; bit 0 is constant 0.
REQ-022 issue_valid=1 and issue_reg!=0: busy[issue_reg] <= 1 on the clock edge; issue to register 0 is ignored.
REQ-023 reg_write=1 and write_reg!=0: busy[write_reg] <= 0 on the clock edge.
REQ-024 Same edge, issue_reg==write_reg (nonzero), both valid: data is written and busy ends at 1 (issue wins).
REQ-025 read_busy_i = busy[read_reg_i], combinational from registered bits; BYPASS=1 and a clearing write to the same register in that cycle forces read_busy_i = 0.
REQ-026 busy_count is registered and equals popcount of busy bits after each edge, updated incrementally: +1 for a set of a non-busy register, -1 for a clear of a busy register, net 0 when both apply to different registers.
REQ-027 Issuing an already-busy register, or writing a non-busy register, leaves busy_count unchanged.
REQ-028 busy_count never exceeds NREGS-1 and never underflows.

Reset
REQ-029 reset=0 asynchronously clears all registers to 0, all busy bits to 0 and busy_count to 0, regardless of clk.
REQ-030 While reset=0, writes and issues are ignored; read_data = 0 and read_busy = 0 on all ports.
REQ-031 Release of reset mid-operation: no state is retained; the first edge with reset=1 behaves as from power-up.

Verification
REQ-032 Reset, write 0xDEADBEEFCAFEBABE to reg 5, next cycle read port 0 at 5 -> 0xDEADBEEFCAFEBABE; reg 0 -> 0.
REQ-033 BYPASS=1: read port 1 at 10 while writing 0x123456789ABCDEF0 to reg 10 -> same-cycle read_data = 0x123456789ABCDEF0; BYPASS=0 -> old value 0 that cycle, new value next cycle.
REQ-034 Write 0xFEDCBA9876543210 to reg 0, and issue reg 0 -> read 0 returns 0, read_busy 0, busy_count 0.
REQ-035 Issue regs 3, 7, 7 on consecutive cycles -> busy_count 1, 2, 2; write reg 3 -> busy_count 1, read_busy at 3 = 0, at 7 = 1.
REQ-036 Same edge: issue reg 9 and write reg 9 with 0xAA -> reg 9 reads 0xAA, busy[9]=1; issue 4 and write busy reg 7 same edge -> busy_count unchanged.
REQ-037 Assert reset mid-clock-period with busy_count=3 and nonzero registers -> immediately busy_count 0, all reads 0, read_busy all 0.

Source files
------------

// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module   : param_register_file
// Purpose  : Multi-read-port register file with r0 hardwired to zero, optional
//            write-to-read forwarding and a per-register pending-write
//            scoreboard with a registered busy counter.
// Revision : 1.0
// ============================================================================
module param_register_file #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     read_reg,
    output logic [NREAD*XLEN-1:0]   read_data,
    output logic [NREAD-1:0]        read_busy,
    input  logic                    reg_write,
    input  logic [AW-1:0]           write_reg,
    input  logic [XLEN-1:0]         write_data,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_reg,
    output logic [AW:0]             busy_count
);

    localparam logic [AW:0] c_one = {{AW{1'b0}}, 1'b1};

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_count;

    logic             w_wr_en;
    logic             w_iss_en;
    logic             w_inc;
    logic             w_dec;
    logic [NREGS-1:0] w_busy_nxt;

    // Writes and issues targeting r0 are discarded, so r0 never leaves zero.
    assign w_wr_en  = reg_write   && (write_reg != '0);
    assign w_iss_en = issue_valid && (issue_reg != '0);

    // An issue to the register being written keeps it busy, so that write
    // must not count as a clear.
    assign w_inc = w_iss_en && !r_busy[issue_reg];
    assign w_dec = w_wr_en && r_busy[write_reg]
                   && !(w_iss_en && (issue_reg == write_reg));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[write_reg] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_nxt[issue_reg] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_inc && !w_dec) begin
                r_busy_count <= r_busy_count + c_one;
            end else if (w_dec && !w_inc) begin
                r_busy_count <= r_busy_count - c_one;
            end
        end
    end

    assign busy_count = r_busy_count;

    // Outputs are gated by reset so the forwarding path cannot leak write
    // data while the array is held cleared.
    generate
        for (genvar i = 0; i < NREAD; i++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_hit;

            assign w_addr = read_reg[i*AW +: AW];
            assign w_hit  = (BYPASS != 0) && w_wr_en && (w_addr == write_reg);

            assign read_data[i*XLEN +: XLEN] = !reset ? '0
                                             : w_hit  ? write_data
                                             :          r_regs[w_addr];
            assign read_busy[i] = reset && !w_hit && r_busy[w_addr];
        end
    endgenerate

endmodule
`default_nettype wire
